sipo_frame_receiver: RTL and testbench
======================================

# sipo_frame_receiver

Serial-in parallel-out framed receiver; the receiving end of the single-bit serial links driven by the team's shift-register transmitters. Samples `sin` once per clock, detects a start bit, shifts in a WIDTH-bit word MSB first, checks the stop bit, and presents the word on a valid/ready parallel interface. Sits between a serial line and a downstream word consumer (FIFO or register file).

## Interface
- WIDTH, 8, data bits per frame (2..32)
- clk  input  1  rising-edge clock; one serial bit per cycle
- rst  input  1  synchronous, active-high reset
- sin  input  1  serial line; idle level 0
- dout  output  WIDTH  received word, MSB = first data bit received
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- frame_err  output  1  one-cycle pulse: stop bit was 1
- parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 without the macro)
- overrun  output  1  one-cycle pulse: completed word dropped because the output register was still full

## Operation
- Frame on `sin`, one bit per cycle: start bit 1, WIDTH data bits MSB first, [parity bit], stop bit 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: `sin`=1 -> DATA, bit counter cleared; `sin`=0 -> stay.
  - DATA: shift `{shreg[WIDTH-2:0], sin}`; counter increments; after the WIDTH-th bit -> PARITY if macro defined, else STOP.
  - PARITY: compare `sin` with the XOR of the received data bits (even parity); -> STOP.
  - STOP: always -> IDLE. The next start bit is recognised in the cycle immediately after STOP (back-to-back frames, no gap).
- Completion, evaluated in STOP:
  - Any error: stop bit 1 -> frame_err pulse; parity mismatch -> parity_err pulse. Both may pulse together. On any error the word is discarded and dout/dout_valid are unchanged.
  - Good frame with output register free (dout_valid=0, or dout_ready=1 in the same cycle): load dout and set dout_valid.
  - Good frame with output register full and dout_ready=0: drop the new word, keep the old one, pulse overrun.
- Handshake: a word transfers on any cycle with dout_valid=1 and dout_ready=1. After a transfer with no simultaneous load, dout_valid clears. dout is stable while dout_valid=1 and dout_ready=0.
- Simultaneous accept and load: the old word transfers, the new word loads, dout_valid stays 1, and no overrun is reported.
- Reset at any point, including mid-frame: return to IDLE and abort the partial frame. Reset values: dout=0, dout_valid=0, frame_err=0, parity_err=0, overrun=0, shift register=0, counter=0.

## Timing
- Every output is registered; no combinational path from `sin` or `dout_ready` to any output.
- Start bit sampled at edge E0 (IDLE). Data bits sampled at E1..E_WIDTH. Parity, if enabled, at E_WIDTH+1. Stop bit at the next edge, E_S.
- dout, dout_valid, and the error/overrun pulses change at E_S and are visible in the following cycle. Latency from start-bit edge to valid is WIDTH+1 edges, or WIDTH+2 with parity.
- Error and overrun pulses last exactly one cycle.
- Sustained throughput is one word per WIDTH+2 cycles (WIDTH+3 with parity).

## Configuration
- `SIPO_RX_PARITY_EN` defined: the PARITY state is present, one even-parity bit is expected after the data bits, and parity_err is driven. Frame length is WIDTH+3.
- Not defined: there is no PARITY state, parity_err is tied to 0, and frame length is WIDTH+2.

## Test plan
- Reset, then idle `sin`=0 for 20 cycles -> all outputs stay 0 and the FSM stays in IDLE.
- WIDTH=8, no parity, dout_ready=1: `sin` = 1, 1,0,1,0,0,1,0,1, 0 -> dout=0xA5 and dout_valid=1 in the cycle after the stop edge; dout_valid clears one cycle later.
- dout_ready=0 while frame 0x3C completes, immediately followed by frame 0xC3 -> dout holds 0x3C, overrun pulses once at the 0xC3 stop edge; raising dout_ready then transfers 0x3C and dout_valid clears.
- Frame 0x5A with stop bit 1 -> frame_err pulses for one cycle, dout_valid stays 0; the next good frame 0x11 is received correctly.
- `rst` asserted after 4 data bits of a frame, then a complete frame 0xFF -> no output from the aborted frame; dout=0xFF. With `SIPO_RX_PARITY_EN`: data 0x01 with parity bit 0 -> parity_err pulses and the word is dropped; the same data with parity bit 1 -> dout=0x01.

Source files
------------

// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver
//
// Receiving end of a single-bit serial link. The line is sampled once per
// clock. A frame is: start bit (1), WIDTH data bits MSB first, an optional
// even-parity bit, and a stop bit (0). A completed good word is presented on
// a valid/ready parallel interface.
//
// Configuration macro: SIPO_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits and parity_err is driven
//   undefined -> no parity bit, parity_err is tied to 0
//
// Ports:
//   clk         rising-edge clock, one serial bit per cycle
//   rst         synchronous active-high reset
//   sin         serial line, idles at 0
//   dout        received word, MSB = first data bit received
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout this cycle
//   frame_err   one-cycle pulse: stop bit was 1
//   parity_err  one-cycle pulse: parity mismatch
//   overrun     one-cycle pulse: good word dropped, output register full
module sipo_frame_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             par_fail;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. STOP always returns to IDLE so a start bit in the very
  // next cycle begins a new frame with no gap.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sin) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (last_bit) begin
`ifdef SIPO_RX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef SIPO_RX_PARITY_EN
      PARITY: next_state = STOP;
`endif
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sin) begin
            cnt <= '0;
          end
        end
        DATA: begin
          shreg <= {shreg[WIDTH-2:0], sin};
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SIPO_RX_PARITY_EN
  // By the PARITY cycle the shift register holds the complete word, so its
  // reduction XOR is the expected even-parity bit. The result is held until
  // the stop bit arrives in the next cycle.
  logic par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad <= 1'b0;
    end else if (state == PARITY) begin
      par_bad <= sin ^ (^shreg);
    end
  end

  assign par_fail = par_bad;
`else
  assign par_fail   = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Output register, handshake and completion pulses. A transfer clears
  // dout_valid unless a good word is loaded in the same cycle, in which case
  // the load wins and dout_valid stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (state == STOP) begin
        if (sin) begin
          frame_err <= 1'b1;
        end
`ifdef SIPO_RX_PARITY_EN
        if (par_fail) begin
          parity_err <= 1'b1;
        end
`endif
        if (!sin && !par_fail) begin
          if (!dout_valid || dout_ready) begin
            dout       <= shreg;
            dout_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver
//
// Self-checking bench for sipo_frame_receiver (WIDTH=8). Words expected to
// reach the consumer are pushed to a scoreboard queue when their frame is
// driven; a monitor pops and compares each word as it is handed over.
// Honours SIPO_RX_PARITY_EN the same way as the design.
module tb_sipo_frame_receiver;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  int               check_count;
  int               error_count;
  int               frame_err_cycles;
  int               parity_err_cycles;
  int               overrun_cycles;
  logic [WIDTH-1:0] sb_q[$];

  sipo_frame_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count a comparison and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one serial bit; returns at the falling edge after it was sampled.
  task automatic driveBit(input logic b);
    sin = b;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      driveBit(1'b0);
    end
  endtask

  // Drive a full frame. stop_bit is normally 0; par_flip inverts the parity
  // bit when parity is enabled.
  task automatic applyStimulus(input logic [WIDTH-1:0] data,
                               input logic stop_bit, input logic par_flip);
    driveBit(1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      driveBit(data[i]);
    end
`ifdef SIPO_RX_PARITY_EN
    driveBit((^data) ^ par_flip);
`else
    if (par_flip) begin
      $display("[TB] note: parity flip ignored without parity");
    end
`endif
    driveBit(stop_bit);
  endtask

  // Monitor: sample just after the falling edge, when dout_ready for the
  // coming rising edge is settled. A word transfers whenever valid and ready
  // are both high at that edge.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (frame_err)  frame_err_cycles++;
      if (parity_err) parity_err_cycles++;
      if (overrun)    overrun_cycles++;
      if (dout_valid && dout_ready) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_word", {24'h0, dout}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_dout", {24'h0, dout}, {24'h0, sb_q.pop_front()});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [WIDTH-1:0] w;
    check_count       = 0;
    error_count       = 0;
    frame_err_cycles  = 0;
    parity_err_cycles = 0;
    overrun_cycles    = 0;
    rst        = 1'b1;
    sin        = 1'b0;
    dout_ready = 1'b1;

    // Reset and idle line.
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", {24'h0, dout}, 32'h0);
    checkOutput("rst_valid", {31'h0, dout_valid}, 32'h0);
    checkOutput("rst_frame_err", {31'h0, frame_err}, 32'h0);
    checkOutput("rst_parity_err", {31'h0, parity_err}, 32'h0);
    checkOutput("rst_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    idleCycles(20);
    checkOutput("idle_valid", {31'h0, dout_valid}, 32'h0);
    checkOutput("idle_dout", {24'h0, dout}, 32'h0);
    checkOutput("idle_pulses", frame_err_cycles + parity_err_cycles + overrun_cycles, 0);

    // Single frame 0xA5 with a ready consumer.
    $display("[TB] frame 0xA5");
    sb_q.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b0, 1'b0);
    checkOutput("a5_valid", {31'h0, dout_valid}, 32'h1);
    checkOutput("a5_dout", {24'h0, dout}, 32'hA5);
    idleCycles(1);
    checkOutput("a5_valid_clear", {31'h0, dout_valid}, 32'h0);

    // Overrun: 0x3C held, 0xC3 back-to-back is dropped.
    $display("[TB] overrun 0x3C / 0xC3");
    dout_ready = 1'b0;
    sb_q.push_back(8'h3C);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("ovr_first_overrun", {31'h0, overrun}, 32'h0);
    applyStimulus(8'hC3, 1'b0, 1'b0);
    checkOutput("ovr_pulse", {31'h0, overrun}, 32'h1);
    checkOutput("ovr_hold_dout", {24'h0, dout}, 32'h3C);
    checkOutput("ovr_hold_valid", {31'h0, dout_valid}, 32'h1);
    idleCycles(1);
    checkOutput("ovr_pulse_end", {31'h0, overrun}, 32'h0);
    dout_ready = 1'b1;
    idleCycles(1);
    checkOutput("ovr_drain_valid", {31'h0, dout_valid}, 32'h0);

    // Framing error then a good frame.
    $display("[TB] frame error 0x5A then 0x11");
    applyStimulus(8'h5A, 1'b1, 1'b0);
    checkOutput("ferr_pulse", {31'h0, frame_err}, 32'h1);
    checkOutput("ferr_valid", {31'h0, dout_valid}, 32'h0);
    idleCycles(1);
    checkOutput("ferr_pulse_end", {31'h0, frame_err}, 32'h0);
    sb_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b0, 1'b0);
    checkOutput("after_ferr_dout", {24'h0, dout}, 32'h11);
    idleCycles(2);

    // Simultaneous accept and load: no overrun, both words delivered.
    $display("[TB] accept and load in the same cycle");
    dout_ready = 1'b0;
    sb_q.push_back(8'h96);
    sb_q.push_back(8'h69);
    applyStimulus(8'h96, 1'b0, 1'b0);
    driveBit(1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      driveBit(w_bit(8'h69, i));
    end
`ifdef SIPO_RX_PARITY_EN
    driveBit(^8'h69);
`endif
    dout_ready = 1'b1;
    driveBit(1'b0);
    checkOutput("sim_overrun", {31'h0, overrun}, 32'h0);
    checkOutput("sim_valid", {31'h0, dout_valid}, 32'h1);
    checkOutput("sim_dout", {24'h0, dout}, 32'h69);
    idleCycles(2);

    // Reset mid-frame aborts the partial word.
    $display("[TB] reset mid-frame");
    driveBit(1'b1);
    for (int i = 0; i < 4; i++) begin
      driveBit(1'b1);
    end
    rst = 1'b1;
    driveBit(1'b0);
    rst = 1'b0;
    checkOutput("midrst_dout", {24'h0, dout}, 32'h0);
    checkOutput("midrst_valid", {31'h0, dout_valid}, 32'h0);
    idleCycles(6);
    checkOutput("midrst_no_word", {31'h0, dout_valid}, 32'h0);
    sb_q.push_back(8'hFF);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    checkOutput("midrst_ff", {24'h0, dout}, 32'hFF);
    idleCycles(1);

`ifdef SIPO_RX_PARITY_EN
    // Parity error drops the word; correct parity delivers it.
    $display("[TB] parity 0x01");
    applyStimulus(8'h01, 1'b0, 1'b1);
    checkOutput("perr_pulse", {31'h0, parity_err}, 32'h1);
    checkOutput("perr_valid", {31'h0, dout_valid}, 32'h0);
    sb_q.push_back(8'h01);
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("perr_pulse_end", {31'h0, parity_err}, 32'h0);
    checkOutput("par_good_dout", {24'h0, dout}, 32'h01);
    idleCycles(1);
`endif

    // Back-to-back random frames at full rate.
    $display("[TB] random back-to-back frames");
    for (int n = 0; n < 8; n++) begin
      w = WIDTH'($urandom);
      sb_q.push_back(w);
      applyStimulus(w, 1'b0, 1'b0);
    end
    idleCycles(3);

    checkOutput("sb_empty", sb_q.size(), 0);
    checkOutput("frame_err_cycles", frame_err_cycles, 1);
    checkOutput("overrun_cycles", overrun_cycles, 1);
`ifdef SIPO_RX_PARITY_EN
    checkOutput("parity_err_cycles", parity_err_cycles, 1);
`else
    checkOutput("parity_err_cycles", parity_err_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  function automatic logic w_bit(input logic [WIDTH-1:0] v, input int i);
    return v[i];
  endfunction

endmodule
